// File: rtl/fighter_action_arbiter_if.sv
// ---------------------------------------------------------------------------
// fighter_action_arbiter_if
// Bundles the per-fighter control inputs (decoded key, motion permissions,
// hit report) and the registered animation outputs of the action arbiter.
//
//   keycode        8  current key code from the keyboard decoder
//   move_right     1  boundary logic permits rightward motion
//   move_left      1  boundary logic permits leftward motion
//   hit_stun       1  collision logic reports a hit (level, sampled per tick)
//   action         3  0 idle, 1 run, 2 punch, 3 kick, 4 block, 5 stun
//   sprite_idx     3  frame within the action, 0 when idle/cooldown
//   attack_active  1  strike frame of a punch or kick
//   busy           1  fighter is in a key-immune state
//   facing         1  0 right, 1 left
//
// master: the side driving requests (game logic / testbench)
// slave : the arbiter itself
// ---------------------------------------------------------------------------
interface fighter_action_arbiter_if;
    logic [7:0] keycode;
    logic       move_right;
    logic       move_left;
    logic       hit_stun;
    logic [2:0] action;
    logic [2:0] sprite_idx;
    logic       attack_active;
    logic       busy;
    logic       facing;

    modport master (
        output keycode, move_right, move_left, hit_stun,
        input  action, sprite_idx, attack_active, busy, facing
    );

    modport slave (
        input  keycode, move_right, move_left, hit_stun,
        output action, sprite_idx, attack_active, busy, facing
    );
endinterface

// File: rtl/fighter_action_arbiter.sv
// ---------------------------------------------------------------------------
// fighter_action_arbiter
// Decides which animation owns the fighter sprite on every video frame tick:
// idle, run, punch, kick, block or hit-stun, with a post-attack cooldown.
// Keyboard requests are arbitrated against non-preemptible attacks and an
// externally forced stun; the sprite frame index advances once every
// HOLD_FRAMES ticks.
//
// Ports
//   i_frame_clk  sole clock, one tick per video frame
//   i_reset_n    asynchronous, active-low reset
//   io_bus       fighter_action_arbiter_if.slave (requests in, outputs out)
//
// Every output is a register loaded from the next-state decode, so the
// sprite address generator sees glitch-free values.
// ---------------------------------------------------------------------------
module fighter_action_arbiter #(
    parameter int HOLD_FRAMES    = 11,
    parameter int RUN_FRAMES     = 4,
    parameter int PUNCH_FRAMES   = 3,
    parameter int KICK_FRAMES    = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int STUN_TICKS     = 22
) (
    input  logic                      i_frame_clk,
    input  logic                      i_reset_n,
    fighter_action_arbiter_if.slave   io_bus
);

    // Counters share one width, large enough for the longest terminal count.
    localparam int MAX_A   = (HOLD_FRAMES > COOLDOWN_TICKS) ? HOLD_FRAMES : COOLDOWN_TICKS;
    localparam int MAX_CNT = (MAX_A > STUN_TICKS) ? MAX_A : STUN_TICKS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [CNT_W-1:0] STUN_LAST = CNT_W'(STUN_TICKS - 1);
    localparam logic [2:0]       RUN_LAST  = 3'(RUN_FRAMES);
    localparam logic [2:0]       PUNCH_LAST = 3'(PUNCH_FRAMES);
    localparam logic [2:0]       KICK_LAST = 3'(KICK_FRAMES);

    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_PUNCH = 8'h0D;
    localparam logic [7:0] KEY_KICK  = 8'h0E;
    localparam logic [7:0] KEY_BLOCK = 8'h16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PUNCH,
        S_KICK,
        S_BLOCK,
        S_STUN,
        S_COOLDOWN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_tcnt;
    logic [2:0]       r_idx;
    logic             r_facing;
    logic [2:0]       r_action;
    logic             r_attack;
    logic             r_busy;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_hold_next;
    logic [CNT_W-1:0] w_tcnt_next;
    logic [2:0]       w_idx_next;
    logic             w_facing_next;
    logic [2:0]       w_action_next;
    logic             w_attack_next;
    logic             w_busy_next;
    logic [2:0]       w_attack_last;

    logic w_key_right;
    logic w_key_left;
    logic w_run_req;

    assign w_key_right = (io_bus.keycode == KEY_RIGHT);
    assign w_key_left  = (io_bus.keycode == KEY_LEFT);
    // A direction key only starts/continues a run if the boundary allows it.
    assign w_run_req   = (w_key_right && io_bus.move_right) ||
                         (w_key_left  && io_bus.move_left);

    // -----------------------------------------------------------------------
    // State, counters and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_frame_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_tcnt   <= '0;
            r_idx    <= '0;
            r_facing <= 1'b0;
            r_action <= '0;
            r_attack <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_hold   <= w_hold_next;
            r_tcnt   <= w_tcnt_next;
            r_idx    <= w_idx_next;
            r_facing <= w_facing_next;
            r_action <= w_action_next;
            r_attack <= w_attack_next;
            r_busy   <= w_busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: hit_stun > busy continuation > punch > kick > block
    // > run > idle.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_hold_next   = r_hold;
        w_tcnt_next   = r_tcnt;
        w_idx_next    = r_idx;
        w_facing_next = r_facing;
        w_attack_last = (r_state == S_PUNCH) ? PUNCH_LAST : KICK_LAST;

        if (io_bus.hit_stun) begin
            // A hit in any state (including an ongoing stun) restarts the stun;
            // a simultaneous attack key is simply dropped.
            w_state_next = S_STUN;
            w_tcnt_next  = '0;
            w_hold_next  = '0;
            w_idx_next   = 3'd1;
        end else begin
            case (r_state)
                S_IDLE, S_RUN, S_BLOCK: begin
                    // Facing follows the direction key even when blocked by a wall.
                    if (w_key_right) begin
                        w_facing_next = 1'b0;
                    end else if (w_key_left) begin
                        w_facing_next = 1'b1;
                    end

                    w_tcnt_next = '0;
                    if (io_bus.keycode == KEY_PUNCH) begin
                        w_state_next = S_PUNCH;
                        w_idx_next   = 3'd1;
                        w_hold_next  = '0;
                    end else if (io_bus.keycode == KEY_KICK) begin
                        w_state_next = S_KICK;
                        w_idx_next   = 3'd1;
                        w_hold_next  = '0;
                    end else if (io_bus.keycode == KEY_BLOCK) begin
                        w_state_next = S_BLOCK;
                        w_idx_next   = 3'd1;
                        w_hold_next  = '0;
                    end else if (w_run_req) begin
                        w_state_next = S_RUN;
                        if (r_state == S_RUN) begin
                            // Continuing run (either direction) keeps the cycle phase.
                            if (r_hold == HOLD_LAST) begin
                                w_hold_next = '0;
                                w_idx_next  = (r_idx == RUN_LAST) ? 3'd1 : r_idx + 3'd1;
                            end else begin
                                w_hold_next = r_hold + 1'b1;
                            end
                        end else begin
                            w_idx_next  = 3'd1;
                            w_hold_next = '0;
                        end
                    end else begin
                        w_state_next = S_IDLE;
                        w_idx_next   = '0;
                        w_hold_next  = '0;
                    end
                end

                S_PUNCH, S_KICK: begin
                    if (r_hold == HOLD_LAST) begin
                        w_hold_next = '0;
                        if (r_idx == w_attack_last) begin
                            w_state_next = S_COOLDOWN;
                            w_idx_next   = '0;
                            w_tcnt_next  = '0;
                        end else begin
                            w_idx_next = r_idx + 3'd1;
                        end
                    end else begin
                        w_hold_next = r_hold + 1'b1;
                    end
                end

                S_COOLDOWN: begin
                    if (r_tcnt == COOL_LAST) begin
                        w_state_next = S_IDLE;
                        w_tcnt_next  = '0;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end

                S_STUN: begin
                    if (r_tcnt == STUN_LAST) begin
                        w_state_next = S_IDLE;
                        w_idx_next   = '0;
                        w_tcnt_next  = '0;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                    w_hold_next  = '0;
                    w_tcnt_next  = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode of the next state, loaded into the output registers.
    // -----------------------------------------------------------------------
    always_comb begin
        w_action_next = 3'd0;
        w_attack_next = 1'b0;
        w_busy_next   = 1'b0;
        case (w_state_next)
            S_RUN:   w_action_next = 3'd1;
            S_PUNCH: begin
                w_action_next = 3'd2;
                w_busy_next   = 1'b1;
                w_attack_next = (w_idx_next == 3'd2);
            end
            S_KICK: begin
                w_action_next = 3'd3;
                w_busy_next   = 1'b1;
                w_attack_next = (w_idx_next == 3'd3);
            end
            S_BLOCK: w_action_next = 3'd4;
            S_STUN: begin
                w_action_next = 3'd5;
                w_busy_next   = 1'b1;
            end
            S_COOLDOWN: w_busy_next = 1'b1;
            default: ;
        endcase
    end

    assign io_bus.action        = r_action;
    assign io_bus.sprite_idx    = r_idx;
    assign io_bus.attack_active = r_attack;
    assign io_bus.busy          = r_busy;
    assign io_bus.facing        = r_facing;

endmodule

// File: tb/tb_fighter_action_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fighter_action_arbiter
// Drives directed scenarios followed by random key/permission/hit traffic.
// The reference model tracks only the current activity and the number of
// ticks spent in it; frame indices are derived from that elapsed count with
// plain division. Expected outputs are queued by the driver and consumed by
// an independent monitor one tick later.
// ---------------------------------------------------------------------------
module tb_fighter_action_arbiter;

    localparam int H     = 11;
    localparam int RUNF  = 4;
    localparam int PF    = 3;
    localparam int KF    = 4;
    localparam int COOL  = 8;
    localparam int STUN  = 22;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PUNCH = 2;
    localparam int M_KICK  = 3;
    localparam int M_BLOCK = 4;
    localparam int M_STUN  = 5;
    localparam int M_COOL  = 6;

    typedef struct packed {
        logic [2:0] act;
        logic [2:0] idx;
        logic       atk;
        logic       busy;
        logic       face;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fighter_action_arbiter_if bus ();

    fighter_action_arbiter #(
        .HOLD_FRAMES    (H),
        .RUN_FRAMES     (RUNF),
        .PUNCH_FRAMES   (PF),
        .KICK_FRAMES    (KF),
        .COOLDOWN_TICKS (COOL),
        .STUN_TICKS     (STUN)
    ) dut (
        .i_frame_clk (clk),
        .i_reset_n   (rst_n),
        .io_bus      (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    int   n_tick = 0;

    // Reference model state: activity, ticks spent in it, facing.
    int m_act  = M_IDLE;
    int m_t    = 0;
    bit m_face = 1'b0;

    function automatic void model_reset();
        m_act  = M_IDLE;
        m_t    = 0;
        m_face = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] kc, input bit mr, input bit ml, input bit hit);
        bit run_req;
        run_req = (kc == 8'h07 && mr) || (kc == 8'h04 && ml);
        if (hit) begin
            m_act = M_STUN;
            m_t   = 0;
        end else begin
            case (m_act)
                M_STUN: begin
                    if (m_t + 1 == STUN) begin m_act = M_IDLE; m_t = 0; end
                    else m_t++;
                end
                M_PUNCH, M_KICK: begin
                    m_t++;
                    if (m_t == ((m_act == M_PUNCH) ? PF : KF) * H) begin
                        m_act = M_COOL;
                        m_t   = 0;
                    end
                end
                M_COOL: begin
                    m_t++;
                    if (m_t == COOL) begin m_act = M_IDLE; m_t = 0; end
                end
                default: begin
                    if (kc == 8'h07) m_face = 1'b0;
                    else if (kc == 8'h04) m_face = 1'b1;
                    if (kc == 8'h0D) begin m_act = M_PUNCH; m_t = 0; end
                    else if (kc == 8'h0E) begin m_act = M_KICK; m_t = 0; end
                    else if (kc == 8'h16) begin m_act = M_BLOCK; m_t = 0; end
                    else if (run_req) begin
                        if (m_act == M_RUN) m_t++;
                        else begin m_act = M_RUN; m_t = 0; end
                    end else begin
                        m_act = M_IDLE;
                        m_t   = 0;
                    end
                end
            endcase
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   frame;
        e      = '0;
        e.face = m_face;
        frame  = m_t / H + 1;
        case (m_act)
            M_RUN:   begin e.act = 3'd1; e.idx = 3'(((m_t / H) % RUNF) + 1); end
            M_PUNCH: begin e.act = 3'd2; e.idx = 3'(frame); e.atk = (frame == 2); e.busy = 1'b1; end
            M_KICK:  begin e.act = 3'd3; e.idx = 3'(frame); e.atk = (frame == 3); e.busy = 1'b1; end
            M_BLOCK: begin e.act = 3'd4; e.idx = 3'd1; end
            M_STUN:  begin e.act = 3'd5; e.idx = 3'd1; e.busy = 1'b1; end
            M_COOL:  begin e.busy = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got = {bus.action, bus.sprite_idx, bus.attack_active, bus.busy, bus.facing};
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s tick %0d: got act=%0d idx=%0d atk=%0b busy=%0b face=%0b, required act=%0d idx=%0d atk=%0b busy=%0b face=%0b",
                     name, n_tick, got.act, got.idx, got.atk, got.busy, got.face,
                     e.act, e.idx, e.atk, e.busy, e.face);
        end
    endtask

    // Drive one tick's inputs (called right after a falling edge).
    task automatic tick_body(input logic [7:0] kc, input bit mr, input bit ml, input bit hit);
        bus.keycode    = kc;
        bus.move_right = mr;
        bus.move_left  = ml;
        bus.hit_stun   = hit;
        model_step(kc, mr, ml, hit);
        q.push_back(model_out());
        n_push++;
    endtask

    task automatic tick(input logic [7:0] kc, input bit mr, input bit ml, input bit hit);
        @(negedge clk);
        tick_body(kc, mr, ml, hit);
    endtask

    task automatic ticks(input int n, input logic [7:0] kc, input bit mr, input bit ml);
        for (int i = 0; i < n; i++) tick(kc, mr, ml, 1'b0);
    endtask

    // Monitor: one expected entry per rising edge once traffic is flowing.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_pop++;
                n_tick++;
                $display("tick %0d key=%h act=%0d idx=%0d atk=%0b busy=%0b face=%0b",
                         n_tick, bus.keycode, bus.action, bus.sprite_idx,
                         bus.attack_active, bus.busy, bus.facing);
                check("tick", e);
            end
        end
    end

    initial begin
        exp_t zero;
        zero           = '0;
        bus.keycode    = 8'h00;
        bus.move_right = 1'b0;
        bus.move_left  = 1'b0;
        bus.hit_stun   = 1'b0;
        model_reset();

        #7;
        check("reset_state", zero);
        @(negedge clk);
        rst_n = 1'b1;

        // Run right for 50 ticks: idx cycles 1..4 every 11 ticks.
        ticks(50, 8'h07, 1'b1, 1'b0);
        ticks(3, 8'h00, 1'b0, 1'b0);

        // Left key without permission: stays idle, facing turns left.
        ticks(3, 8'h04, 1'b0, 1'b0);

        // Punch tap, then full punch + cooldown with keys present.
        tick(8'h0D, 1'b0, 1'b0, 1'b0);
        ticks(20, 8'h00, 1'b0, 1'b0);
        ticks(25, 8'h07, 1'b1, 1'b0);
        ticks(3, 8'h00, 1'b0, 1'b0);

        // Kick, punch key during idx 2 must be ignored.
        tick(8'h0E, 1'b0, 1'b0, 1'b0);
        ticks(12, 8'h00, 1'b0, 1'b0);
        ticks(5, 8'h0D, 1'b0, 1'b0);
        ticks(40, 8'h00, 1'b0, 1'b0);

        // Hit during punch idx 2, then a re-hit at stun tick 10.
        tick(8'h0D, 1'b0, 1'b0, 1'b0);
        ticks(12, 8'h00, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b1);
        ticks(9, 8'h00, 1'b0, 1'b0);
        tick(8'h0E, 1'b0, 1'b0, 1'b1);
        ticks(30, 8'h00, 1'b0, 1'b0);

        // Block held then released; switch straight from block to run.
        ticks(5, 8'h16, 1'b0, 1'b0);
        ticks(4, 8'h04, 1'b0, 1'b1 == 1'b1);
        ticks(2, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset while running at idx 3.
        ticks(25, 8'h07, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", zero);
        q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick_body(8'h07, 1'b1, 1'b0, 1'b0);
        ticks(5, 8'h07, 1'b1, 1'b0);

        // Randomised traffic.
        for (int seg = 0; seg < 120; seg++) begin
            logic [7:0] kc;
            int         len;
            bit         mr;
            bit         ml;
            case ($urandom_range(0, 7))
                0: kc = 8'h07;
                1: kc = 8'h04;
                2: kc = 8'h0D;
                3: kc = 8'h0E;
                4: kc = 8'h16;
                5: kc = 8'h00;
                6: kc = 8'($urandom);
                default: kc = 8'h07;
            endcase
            mr  = ($urandom_range(0, 3) != 0);
            ml  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                tick(kc, mr, ml, ($urandom_range(0, 99) < 2));
            end
        end

        // Let the monitor drain, then confirm every expectation was consumed.
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (n_pop != n_push) begin
            n_bad++;
            $display("FAIL drain: popped %0d, required %0d", n_pop, n_push);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
